// File: rtl/commit_arbiter.sv
// ---------------------------------------------------------------------------
// commit_arbiter
//
// Responder side of the reservation-station commit handshake. Each station
// (bit 0=ADD0, 1=ADD1, 2=DIV, 3=MUL, 4=SQRT) raises a commit request and holds
// it until granted. One station is granted per cycle in round-robin order.
// The winner's {dst, we[2:0], x, y, z} entry is registered onto a single
// commit bus feeding the register-file writeback port and operand forwarding.
//
// Ports
//   Clock            system clock, all logic on posedge
//   Reset            synchronous, active-high
//   iCommitRequest   per-station request, held until granted
//   iCommitData      per-station {dst,we,x,y,z}, packed, station 0 at LSBs
//   iWriteBackStall  writeback port busy: no grant registered this cycle
//   oCommitGranted   one-hot grant pulse, one cycle
//   oCommitValid     commit bus carries a valid entry
//   oCommitRsId      index of committing station
//   oCommitBus       {dst,we,x,y,z} of committing station (holds when idle)
//   oCommitCount     total grants (statistics build only, else 0)
//   oStallCycles     cycles with a request pending and no grant (stats only)
//
// Optional feature macro: COMMIT_ARB_STATS_EN builds the two 32-bit
// statistics counters; without it both outputs are tied to zero.
// ---------------------------------------------------------------------------
module commit_arbiter #(
    parameter int NUM_RS = 5,
    parameter int DST_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                                     Clock,
    input  logic                                     Reset,
    input  logic [NUM_RS-1:0]                        iCommitRequest,
    input  logic [NUM_RS*(DST_W+3+3*DATA_W)-1:0]     iCommitData,
    input  logic                                     iWriteBackStall,
    output logic [NUM_RS-1:0]                        oCommitGranted,
    output logic                                     oCommitValid,
    output logic [2:0]                               oCommitRsId,
    output logic [DST_W+3+3*DATA_W-1:0]              oCommitBus,
    output logic [31:0]                              oCommitCount,
    output logic [31:0]                              oStallCycles
);

    localparam int ENTRY_W = DST_W + 3 + 3*DATA_W;

    logic [ENTRY_W-1:0] entries [NUM_RS];
    logic [NUM_RS-1:0]  eligible;
    logic [NUM_RS-1:0]  winner_onehot;
    logic [2:0]         ptr;
    logic [2:0]         ptr_next;
    logic [2:0]         winner;
    logic [2:0]         cand;
    logic               grant_now;

    // Station index 'offset' places after 'base', wrapping NUM_RS-1 -> 0.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_RS) begin
            sum = sum - NUM_RS;
        end
        return 3'(sum);
    endfunction

    // Unpack the flat per-station data vector into one entry per station.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            entries[i] = iCommitData[i*ENTRY_W +: ENTRY_W];
        end
    end

    // The station granted last cycle is still holding its request this
    // cycle; the registered grant doubles as the mask against a re-grant.
    assign eligible = iCommitRequest & ~oCommitGranted;

    // Round-robin scan starting at ptr; the first eligible station wins.
    always_comb begin
        grant_now     = 1'b0;
        winner        = '0;
        cand          = '0;
        winner_onehot = '0;
        if (!iWriteBackStall) begin
            for (int k = 0; k < NUM_RS; k++) begin
                cand = rr_index(ptr, k);
                if (!grant_now && eligible[cand]) begin
                    grant_now = 1'b1;
                    winner    = cand;
                end
            end
        end
        if (grant_now) begin
            winner_onehot[winner] = 1'b1;
        end
    end

    assign ptr_next = (winner == 3'(NUM_RS-1)) ? 3'd0 : winner + 3'd1;

    // Grant/commit register. When nothing is granted the bus and station id
    // hold, only the pulse and valid drop, and the mask clears with them.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oCommitGranted <= '0;
            oCommitValid   <= 1'b0;
            oCommitRsId    <= '0;
            oCommitBus     <= '0;
            ptr            <= '0;
        end else if (grant_now) begin
            oCommitGranted <= winner_onehot;
            oCommitValid   <= 1'b1;
            oCommitRsId    <= winner;
            oCommitBus     <= entries[winner];
            ptr            <= ptr_next;
        end else begin
            oCommitGranted <= '0;
            oCommitValid   <= 1'b0;
        end
    end

`ifdef COMMIT_ARB_STATS_EN
    // Statistics: a stall cycle is any cycle with a request raised (even a
    // masked one) that ends without a registered grant. Both wrap at 2^32.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oCommitCount <= '0;
            oStallCycles <= '0;
        end else begin
            if (grant_now) begin
                oCommitCount <= oCommitCount + 32'd1;
            end
            if ((|iCommitRequest) && !grant_now) begin
                oStallCycles <= oStallCycles + 32'd1;
            end
        end
    end
`else
    assign oCommitCount = '0;
    assign oStallCycles = '0;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_commit_arbiter
//
// Directed self-checking bench for commit_arbiter: reset state, single
// commit, full round-robin sweep with wrap, lone-station mask alternation,
// writeback stall, reset during a grant, and the statistics counters
// (expected zero when COMMIT_ARB_STATS_EN is not defined).
// ---------------------------------------------------------------------------
module tb_commit_arbiter;

    localparam int NUM_RS  = 5;
    localparam int DST_W   = 8;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = DST_W + 3 + 3*DATA_W;

    logic                        Clock;
    logic                        Reset;
    logic [NUM_RS-1:0]           iCommitRequest;
    logic [NUM_RS*ENTRY_W-1:0]   iCommitData;
    logic                        iWriteBackStall;
    logic [NUM_RS-1:0]           oCommitGranted;
    logic                        oCommitValid;
    logic [2:0]                  oCommitRsId;
    logic [ENTRY_W-1:0]          oCommitBus;
    logic [31:0]                 oCommitCount;
    logic [31:0]                 oStallCycles;

    int checks = 0;
    int errors = 0;

    logic [NUM_RS-1:0] req;

    commit_arbiter #(
        .NUM_RS (NUM_RS),
        .DST_W  (DST_W),
        .DATA_W (DATA_W)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .iCommitRequest  (iCommitRequest),
        .iCommitData     (iCommitData),
        .iWriteBackStall (iWriteBackStall),
        .oCommitGranted  (oCommitGranted),
        .oCommitValid    (oCommitValid),
        .oCommitRsId     (oCommitRsId),
        .oCommitBus      (oCommitBus),
        .oCommitCount    (oCommitCount),
        .oStallCycles    (oStallCycles)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Distinct entry per station; MUL (3) carries we=000 to show a
    // no-write commit is granted like any other.
    function automatic logic [ENTRY_W-1:0] make_entry(input int i);
        logic [DST_W-1:0]  dst;
        logic [2:0]        we;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] z;
        dst = 8'h20 + 8'(i);
        we  = (i == 3) ? 3'b000 : 3'(i + 1);
        x   = 32'hA000_0000 + 32'(i);
        y   = 32'hB000_0100 + 32'(i * 3);
        z   = 32'hC0DE_0000 ^ 32'(i << 8);
        return {dst, we, x, y, z};
    endfunction

    // Drive inputs, then advance one clock and settle past the edge.
    task automatic applyStimulus(input logic [NUM_RS-1:0] r, input logic stall, input logic rst);
        iCommitRequest  = r;
        iWriteBackStall = stall;
        Reset           = rst;
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [NUM_RS-1:0] g, input logic v,
                               input logic [2:0] id, input logic [ENTRY_W-1:0] bus);
        checks++;
        assert (oCommitGranted === g) else begin
            errors++;
            $error("[TB] FAIL %s grant observed=%b expected=%b", tag, oCommitGranted, g);
        end
        checks++;
        assert (oCommitValid === v) else begin
            errors++;
            $error("[TB] FAIL %s valid observed=%b expected=%b", tag, oCommitValid, v);
        end
        if (v) begin
            checks++;
            assert (oCommitRsId === id) else begin
                errors++;
                $error("[TB] FAIL %s rsid observed=%0d expected=%0d", tag, oCommitRsId, id);
            end
        end
        checks++;
        assert (oCommitBus === bus) else begin
            errors++;
            $error("[TB] FAIL %s bus observed=%h expected=%h", tag, oCommitBus, bus);
        end
    endtask

    task automatic checkStats(input string tag, input logic [31:0] cnt, input logic [31:0] stl);
        logic [31:0] exp_cnt;
        logic [31:0] exp_stl;
`ifdef COMMIT_ARB_STATS_EN
        exp_cnt = cnt;
        exp_stl = stl;
`else
        exp_cnt = 32'd0 & cnt;
        exp_stl = 32'd0 & stl;
`endif
        checks++;
        assert (oCommitCount === exp_cnt) else begin
            errors++;
            $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, oCommitCount, exp_cnt);
        end
        checks++;
        assert (oStallCycles === exp_stl) else begin
            errors++;
            $error("[TB] FAIL %s stall_cycles observed=%0d expected=%0d", tag, oStallCycles, exp_stl);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_RS; i++) begin
            iCommitData[i*ENTRY_W +: ENTRY_W] = make_entry(i);
        end

        // Reset state
        applyStimulus(5'b00000, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0, 1'b1);
        checkOutput("reset", 5'b00000, 1'b0, 3'd0, '0);
        checkStats("reset_stats", 32'd0, 32'd0);

        // Single ADD0 commit, one-cycle latency, then bus holds
        applyStimulus(5'b00001, 1'b0, 1'b0);
        checkOutput("single_add0", 5'b00001, 1'b1, 3'd0, make_entry(0));
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("single_idle", 5'b00000, 1'b0, 3'd0, make_entry(0));

        // Full sweep from ptr=0, each station dropping after its grant
        applyStimulus(5'b00000, 1'b0, 1'b1);
        req = 5'b11111;
        for (int i = 0; i < NUM_RS; i++) begin
            applyStimulus(req, 1'b0, 1'b0);
            checkOutput("rr_sweep", 5'(1 << i), 1'b1, 3'(i), make_entry(i));
            req = req & ~5'(1 << i);
        end
        // ptr wrapped to 0: ADD0 beats ADD1
        applyStimulus(5'b00011, 1'b0, 1'b0);
        checkOutput("rr_wrap", 5'b00001, 1'b1, 3'd0, make_entry(0));
        applyStimulus(5'b00010, 1'b0, 1'b0);
        checkOutput("rr_next", 5'b00010, 1'b1, 3'd1, make_entry(1));
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("rr_idle", 5'b00000, 1'b0, 3'd0, make_entry(1));

        // Lone MUL holding its request: granted every other cycle
        applyStimulus(5'b01000, 1'b0, 1'b0);
        checkOutput("mask_g1", 5'b01000, 1'b1, 3'd3, make_entry(3));
        applyStimulus(5'b01000, 1'b0, 1'b0);
        checkOutput("mask_gap", 5'b00000, 1'b0, 3'd0, make_entry(3));
        applyStimulus(5'b01000, 1'b0, 1'b0);
        checkOutput("mask_g2", 5'b01000, 1'b1, 3'd3, make_entry(3));
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("mask_idle", 5'b00000, 1'b0, 3'd0, make_entry(3));

        // Writeback stall for three cycles, then ADD1 then DIV
        applyStimulus(5'b00000, 1'b0, 1'b1);
        checkOutput("reset2", 5'b00000, 1'b0, 3'd0, '0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00110, 1'b1, 1'b0);
            checkOutput("stall", 5'b00000, 1'b0, 3'd0, '0);
        end
        applyStimulus(5'b00110, 1'b0, 1'b0);
        checkOutput("stall_add1", 5'b00010, 1'b1, 3'd1, make_entry(1));
        applyStimulus(5'b00100, 1'b0, 1'b0);
        checkOutput("stall_div", 5'b00100, 1'b1, 3'd2, make_entry(2));
        applyStimulus(5'b00000, 1'b0, 1'b0);
        checkOutput("stall_idle", 5'b00000, 1'b0, 3'd0, make_entry(2));
        checkStats("stall_stats", 32'd2, 32'd3);

        // Reset while a grant is being driven
        applyStimulus(5'b00001, 1'b0, 1'b0);
        checkOutput("pre_reset_grant", 5'b00001, 1'b1, 3'd0, make_entry(0));
        applyStimulus(5'b00010, 1'b0, 1'b1);
        checkOutput("mid_reset", 5'b00000, 1'b0, 3'd0, '0);
        checkStats("mid_reset_stats", 32'd0, 32'd0);
        // ptr back at 0: ADD0 wins over ADD1
        applyStimulus(5'b00011, 1'b0, 1'b0);
        checkOutput("post_reset_ptr", 5'b00001, 1'b1, 3'd0, make_entry(0));
        checkStats("post_reset_stats", 32'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
